key_event_source: RTL
=====================

// Module: key_event_source
// PURPOSE
//   Input front end for the editor FSM. Scans a 4x4 hex keypad and three push buttons (BS/PRE/NXT).
//   Debounces every input and turns each press into one registered single-cycle pulse:
//   one-hot d[15:0] for keys 0-F, or one of bs/nxt/pre.
//   Holds one pending event and releases it only while the consumer raises ready, so no press is lost
//   while the FSM is outside its wait state. Sits between the board pins and the FSM inputs.
// PARAMETERS
//   SCAN_DIV   250000  clk cycles per keypad row dwell (>=2)
//   DB_SCANS   4       consecutive full 4-row scans a key state must persist to be accepted (>=1)
//   DB_CYCLES  500000  clk cycles a button level must be stable to be accepted (>=2)
// PORTS
//   clk      in   1   system clock
//   rstn     in   1   reset, asynchronous, active-low
//   row      out  4   keypad row drive, active-low, exactly one bit low
//   col      in   4   keypad column sense, active-low (pulled up), asynchronous
//   btn_bs   in   1   raw backspace button, active-high, asynchronous
//   btn_pre  in   1   raw previous button, active-high, asynchronous
//   btn_nxt  in   1   raw next button, active-high, asynchronous
//   ready    in   1   consumer can take an event this cycle (FSM in wait state)
//   d        out  16  one-hot key pulse, bit k = hex key k
//   bs       out  1   backspace pulse
//   nxt      out  1   next pulse
//   pre      out  1   previous pulse
//   pend     out  1   an event is held and not yet delivered
//   ovf      out  1   sticky: an event was dropped; cleared only by reset
// BEHAVIOUR
//   Reset: row=4'b1110 (row_idx 0), d=0, bs=nxt=pre=0, pend=0, ovf=0, all counters/debounce state 0 (released).
//   Sync: col and btn_* each pass through a 2-FF synchronizer before any use.
//   Scan:
//     - row_idx 0..3, wraps 3->0; row = ~(4'b1 << row_idx); dwell counter 0..SCAN_DIV-1.
//     - On the last dwell cycle, sample the synchronized col; then advance row_idx.
//     - Key code = {row_idx[1:0], col_idx[1:0]}; col_idx = position of the single low col bit.
//   Per-scan result, computed at the end of row 3:
//     - NONE: no low col in any row.
//     - ONE(k): exactly one low bit across all 4 rows.
//     - MULTI: anything else.
//   Key debounce FSM, states REL / PRS(k):
//     - REL -> PRS(k) after DB_SCANS consecutive ONE(k) results with the same k; any other result restarts the count.
//     - PRS(k) -> REL after DB_SCANS consecutive NONE results.
//     - PRS ignores ONE(j) and MULTI; they also restart the NONE count.
//     - The REL->PRS(k) transition raises one key event k. Holding a key never repeats.
//   Buttons: each has its own stable counter. Its debounced level changes once the synchronized level
//     differs from it for DB_CYCLES consecutive cycles. A 0->1 debounced edge raises one event.
//   Arbitration (same cycle): key > bs > nxt > pre. The winner is offered to the slot; every loser sets ovf.
//   Slot (1 entry):
//     - An offered event is captured if pend=0, or if pend=1 and a delivery happens this same cycle.
//       Otherwise the event is dropped and ovf<=1.
//     - Capture sets pend on the next edge.
//   Delivery:
//     - When pend=1 and ready=1, exactly one of d[k]/bs/nxt/pre is 1 on the next cycle, for exactly one cycle.
//     - pend clears on that same edge unless a new event is captured.
//     - All pulse outputs are registered; they are 0 in every other cycle, and never more than one is high.
//     - Latency: ready sampled high with pend=1 -> pulse one cycle later.
//     - ready=0 holds the event indefinitely.
//   Reset mid-operation clears the slot, scan position and debounce state immediately. Nothing is delivered after it.
// TESTING (SCAN_DIV=4, DB_SCANS=2, DB_CYCLES=8)
//   Reset: rstn=0 while key 7 is held -> row=1110, all pulses=0, pend=0, ovf=0; after release, row walks 1110->1101->1011->0111, 4 cycles each.
//   Key press: hold col=1110 only while row=1011 (key 8), ready=1 -> after 2 full scans + sync, d=16'h0100 for exactly 1 cycle; held 10 more scans -> no repeat.
//   Bounce: btn_nxt toggles every 3 cycles for 30 cycles, then stays 1 -> exactly one nxt pulse, 8 cycles + sync after it settles.
//   Hold-off: ready=0, press bs -> pend=1, no pulse; 100 cycles later raise ready -> bs pulses next cycle, pend=0.
//   Overflow: ready=0, press key 3, then btn_pre -> pend stays 1 holding key 3, ovf=1; ready=1 -> d=16'h0008, no pre pulse.
//   Simultaneous: btn_bs and btn_nxt debounce on the same cycle, ready=1 -> bs pulses only, ovf=1; MULTI (keys 1+2 held) -> no d pulse.

Source files
------------

// File: rtl/key_event_source.sv
// rtl/key_event_source.sv - keypad scanner, key/button debouncers and one-entry event slot
// Turns debounced presses into single-cycle pulses released only while the consumer is ready.
module key_event_source #(
    parameter int SCAN_DIV  = 250000,
    parameter int DB_SCANS  = 4,
    parameter int DB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    input  logic        btn_bs,
    input  logic        btn_pre,
    input  logic        btn_nxt,
    input  logic        ready,
    output logic [15:0] d,
    output logic        bs,
    output logic        nxt,
    output logic        pre,
    output logic        pend,
    output logic        ovf
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int KW = $clog2(DB_SCANS + 1);
    localparam int BW = $clog2(DB_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [KW-1:0] KEY_TARGET = KW'(DB_SCANS);
    localparam logic [BW-1:0] BTN_LAST   = BW'(DB_CYCLES - 1);

    typedef enum logic {K_REL, K_PRS} kstate_t;
    typedef enum logic [1:0] {EV_KEY, EV_BS, EV_NXT, EV_PRE} ev_kind_t;

    // Button vectors are indexed in priority order: bs, nxt, pre.
    logic [2:0] btn_raw;
    assign btn_raw = {btn_pre, btn_nxt, btn_bs};

    logic [3:0] col_m, col_s;
    logic [2:0] btn_m, btn_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_m <= 4'hF;
            col_s <= 4'hF;
            btn_m <= 3'b000;
            btn_s <= 3'b000;
        end else begin
            col_m <= col;
            col_s <= col_m;
            btn_m <= btn_raw;
            btn_s <= btn_m;
        end
    end

    logic [1:0]    row_idx;
    logic [DW-1:0] dwell;
    logic [1:0]    acc_n;
    logic [3:0]    acc_code;
    logic          scan_done;
    logic [1:0]    scan_n;
    logic [3:0]    scan_code;

    // Low-column counts saturate at 2: only NONE / ONE / MULTI matter.
    logic [1:0] row_n, row_col, tot_n;
    logic [2:0] sum_n;
    logic [3:0] tot_code;

    always_comb begin
        row_n   = 2'd0;
        row_col = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!col_s[i]) begin
                row_col = 2'(i);
                if (row_n != 2'd2) row_n = row_n + 2'd1;
            end
        end
        sum_n    = {1'b0, acc_n} + {1'b0, row_n};
        tot_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        tot_code = (row_n == 2'd1) ? {row_idx, row_col} : acc_code;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row       <= 4'b1110;
            row_idx   <= 2'd0;
            dwell     <= '0;
            acc_n     <= 2'd0;
            acc_code  <= 4'd0;
            scan_done <= 1'b0;
            scan_n    <= 2'd0;
            scan_code <= 4'd0;
        end else begin
            scan_done <= 1'b0;
            if (dwell == DWELL_LAST) begin
                dwell   <= '0;
                row_idx <= row_idx + 2'd1;
                row     <= ~(4'b0001 << (row_idx + 2'd1));
                if (row_idx == 2'd3) begin
                    acc_n     <= 2'd0;
                    acc_code  <= 4'd0;
                    scan_done <= 1'b1;
                    scan_n    <= tot_n;
                    scan_code <= tot_code;
                end else begin
                    acc_n    <= tot_n;
                    acc_code <= tot_code;
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    kstate_t       kstate;
    logic [KW-1:0] kcnt;
    logic [3:0]    cand;
    logic          key_evt;
    logic [3:0]    key_code;
    logic [KW-1:0] kcnt_inc, run;

    assign kcnt_inc = kcnt + KW'(1);
    assign run      = (kcnt != '0 && cand == scan_code) ? kcnt_inc : KW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            kstate   <= K_REL;
            kcnt     <= '0;
            cand     <= 4'd0;
            key_evt  <= 1'b0;
            key_code <= 4'd0;
        end else begin
            key_evt <= 1'b0;
            if (scan_done) begin
                case (kstate)
                    K_REL: begin
                        if (scan_n == 2'd1) begin
                            if (run == KEY_TARGET) begin
                                kstate   <= K_PRS;
                                kcnt     <= '0;
                                key_evt  <= 1'b1;
                                key_code <= scan_code;
                            end else begin
                                kcnt <= run;
                                cand <= scan_code;
                            end
                        end else begin
                            kcnt <= '0;
                        end
                    end
                    K_PRS: begin
                        if (scan_n == 2'd0) begin
                            if (kcnt_inc == KEY_TARGET) begin
                                kstate <= K_REL;
                                kcnt   <= '0;
                            end else begin
                                kcnt <= kcnt_inc;
                            end
                        end else begin
                            kcnt <= '0;
                        end
                    end
                    default: kstate <= K_REL;
                endcase
            end
        end
    end

    logic [2:0]    btn_db, btn_evt;
    logic [BW-1:0] btn_cnt [3];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btn_db  <= 3'b000;
            btn_evt <= 3'b000;
            for (int i = 0; i < 3; i++) btn_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                btn_evt[i] <= 1'b0;
                if (btn_s[i] != btn_db[i]) begin
                    if (btn_cnt[i] == BTN_LAST) begin
                        btn_db[i]  <= btn_s[i];
                        btn_cnt[i] <= '0;
                        btn_evt[i] <= btn_s[i];
                    end else begin
                        btn_cnt[i] <= btn_cnt[i] + BW'(1);
                    end
                end else begin
                    btn_cnt[i] <= '0;
                end
            end
        end
    end

    logic     offer, lose, deliver, capture, drop;
    ev_kind_t win_kind, slot_kind;
    logic [3:0] slot_code;

    always_comb begin
        win_kind = EV_PRE;
        if (key_evt)         win_kind = EV_KEY;
        else if (btn_evt[0]) win_kind = EV_BS;
        else if (btn_evt[1]) win_kind = EV_NXT;
    end

    assign offer   = key_evt | (|btn_evt);
    assign lose    = (key_evt & (|btn_evt)) | (btn_evt[0] & (btn_evt[1] | btn_evt[2]))
                   | (btn_evt[1] & btn_evt[2]);
    assign deliver = pend & ready;
    assign capture = offer & (~pend | deliver);
    assign drop    = offer & ~capture;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d         <= 16'h0000;
            bs        <= 1'b0;
            nxt       <= 1'b0;
            pre       <= 1'b0;
            pend      <= 1'b0;
            ovf       <= 1'b0;
            slot_kind <= EV_KEY;
            slot_code <= 4'd0;
        end else begin
            d   <= 16'h0000;
            bs  <= 1'b0;
            nxt <= 1'b0;
            pre <= 1'b0;
            if (deliver) begin
                case (slot_kind)
                    EV_KEY:  d   <= 16'h0001 << slot_code;
                    EV_BS:   bs  <= 1'b1;
                    EV_NXT:  nxt <= 1'b1;
                    default: pre <= 1'b1;
                endcase
            end
            if (capture) begin
                slot_kind <= win_kind;
                slot_code <= key_code;
                pend      <= 1'b1;
            end else if (deliver) begin
                pend <= 1'b0;
            end
            if (lose | drop) ovf <= 1'b1;
        end
    end

endmodule
